// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue slice: opcode map, request class and
// the stage-1 control payload.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_EQ  = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_LT  = 4'b1100;

  typedef enum logic [1:0] {
    CLS_MEM    = 2'b00,
    CLS_BRANCH = 2'b01,
    CLS_ARITH  = 2'b10,
    CLS_RSVD   = 2'b11
  } alu_class_e;

  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic                invert;
    logic                branch;
    logic                illegal;
  } s1_ctrl_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of class/funct fields into an ALU operation plus
// branch, invert and illegal flags.
module alu_op_decode
  import alu_pkg::*;
(
  input  alu_class_e i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output s1_ctrl_t   o_ctrl_c
);

  always_comb begin
    o_ctrl_c = '0;
    case (i_alu_op)
      CLS_MEM: o_ctrl_c.op = ALU_ADD;
      CLS_BRANCH: begin
        o_ctrl_c.branch = 1'b1;
        case (i_funct3)
          3'b000: o_ctrl_c.op = ALU_EQ;
          3'b001: begin
            o_ctrl_c.op     = ALU_EQ;
            o_ctrl_c.invert = 1'b1;
          end
          3'b100: o_ctrl_c.op = ALU_LT;
          3'b101: begin
            o_ctrl_c.op     = ALU_LT;
            o_ctrl_c.invert = 1'b1;
          end
          default: begin
            o_ctrl_c.branch  = 1'b0;
            o_ctrl_c.illegal = 1'b1;
          end
        endcase
      end
      CLS_ARITH: begin
        case (i_funct3)
          3'b000:  o_ctrl_c.op = i_funct7_5 ? ALU_SUB : ALU_ADD;
          3'b001:  o_ctrl_c.op = ALU_SLL;
          3'b010:  o_ctrl_c.op = ALU_LT;
          3'b100:  o_ctrl_c.op = ALU_XOR;
          3'b101:  o_ctrl_c.op = i_funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  o_ctrl_c.op = ALU_OR;
          3'b111:  o_ctrl_c.op = ALU_AND;
          default: o_ctrl_c.illegal = 1'b1;
        endcase
      end
      default: o_ctrl_c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Two-stage issue pipeline in front of an external combinational ALU:
// stage 1 holds the decoded request, stage 2 holds the returned result.
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               alu_op,
  input  logic [2:0]               funct3,
  input  logic                     funct7_5,
  input  logic [DATA_WIDTH-1:0]    op_a,
  input  logic [DATA_WIDTH-1:0]    op_b,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    result,
  output logic                     branch_taken,
  output logic                     illegal
);

  s1_ctrl_t              w_dec_ctrl;
  s1_ctrl_t              r_s1_ctrl;
  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_src_a;
  logic [DATA_WIDTH-1:0] r_src_b;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_branch_taken;
  logic                  r_illegal;
  logic                  w_s1_adv;
  logic                  w_accept;
  logic                  w_taken;

  alu_op_decode u_decode (
    .i_alu_op   (alu_class_e'(alu_op)),
    .i_funct3   (funct3),
    .i_funct7_5 (funct7_5),
    .o_ctrl_c   (w_dec_ctrl)
  );

  // Stage 1 moves on whenever stage 2 is empty or is being drained this cycle.
  assign w_s1_adv = r_s1_valid && (!r_out_valid || out_ready);
  assign in_ready = !r_s1_valid || w_s1_adv;
  assign w_accept = in_valid && in_ready;
  assign w_taken  = r_s1_ctrl.branch && !r_s1_ctrl.illegal
                    && (ALUResult[0] ^ r_s1_ctrl.invert);

  // Issue register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_ctrl  <= '0;
      r_src_a    <= '0;
      r_src_b    <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_ctrl  <= w_dec_ctrl;
      r_src_a    <= op_a;
      r_src_b    <= op_b;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Result register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid    <= 1'b0;
      r_result       <= '0;
      r_branch_taken <= 1'b0;
      r_illegal      <= 1'b0;
    end else if (w_s1_adv) begin
      r_out_valid    <= 1'b1;
      r_result       <= r_s1_ctrl.illegal ? '0 : ALUResult;
      r_branch_taken <= w_taken;
      r_illegal      <= r_s1_ctrl.illegal;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign SrcA         = r_src_a;
  assign SrcB         = r_src_b;
  assign Operation    = OPCODE_LENGTH'(r_s1_ctrl.op);
  assign out_valid    = r_out_valid;
  assign result       = r_result;
  assign branch_taken = r_branch_taken;
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue with a behavioural model of the external ALU.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] op_a, op_b;
  logic [31:0] SrcA, SrcB;
  logic [3:0]  Operation;
  logic [31:0] ALUResult;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        branch_taken;
  logic        illegal;

  typedef struct {
    logic [31:0] res;
    logic        taken;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;
  int   p0;

  alu_issue dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_op       (alu_op),
    .funct3       (funct3),
    .funct7_5     (funct7_5),
    .op_a         (op_a),
    .op_b         (op_b),
    .SrcA         (SrcA),
    .SrcB         (SrcB),
    .Operation    (Operation),
    .ALUResult    (ALUResult),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  // External ALU model
  always_comb begin
    case (Operation)
      4'b0000: ALUResult = SrcA & SrcB;
      4'b0001: ALUResult = SrcA | SrcB;
      4'b0010: ALUResult = SrcA + SrcB;
      4'b0011: ALUResult = SrcA - SrcB;
      4'b0100: ALUResult = SrcA << SrcB[4:0];
      4'b0101: ALUResult = SrcA >> SrcB[4:0];
      4'b0110: ALUResult = SrcA ^ SrcB;
      4'b0111: ALUResult = 32'($signed(SrcA) >>> SrcB[4:0]);
      4'b1000: ALUResult = {31'd0, SrcA == SrcB};
      4'b1100: ALUResult = {31'd0, $signed(SrcA) < $signed(SrcB)};
      default: ALUResult = 32'd0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops and compares on every output handshake
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_unexpected actual result=%h expected=no output t=%0t", result, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_result", result, e.res);
        chk("mon_taken", 32'(branch_taken), 32'(e.taken));
        chk("mon_illegal", 32'(illegal), 32'(e.ill));
        pops++;
      end
    end
  end

  // Drive a request and wait for acceptance; returns just after the accepting edge
  task automatic send(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic et, input logic ei);
    bit   ok;
    exp_t e;
    ok       = 1'b0;
    in_valid = 1'b1;
    alu_op   = aop;
    funct3   = f3;
    funct7_5 = f7;
    op_a     = a;
    op_b     = b;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok      = 1'b1;
        e.res   = er;
        e.taken = et;
        e.ill   = ei;
        sb.push_back(e);
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual in_ready=0 expected in_ready=1 t=%0t", $time);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 2'b00; funct3 = 3'b000; funct7_5 = 1'b0; op_a = '0; op_b = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_result", result, 32'd0);
    chk("rst_operation", 32'(Operation), 32'd0);
    chk("rst_srca", SrcA, 32'd0);

    // SUB 10-3: latency and stage-1 operation
    @(posedge clk); #1;
    send(2'b10, 3'b000, 1'b1, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("sub_s1_operation", 32'(Operation), 32'h3);
    chk("sub_s1_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("sub_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("sub_out_drop", 32'(out_valid), 32'd0);

    // Branches
    @(posedge clk); #1;
    send(2'b01, 3'b001, 1'b0, 32'd5, 32'd5, 32'd1, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("bne_operation", 32'(Operation), 32'h8);
    @(posedge clk); #1;
    send(2'b01, 3'b101, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1'b0);
    send(2'b01, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b1, 1'b0);
    idle();
    repeat (3) @(negedge clk);

    // Back-to-back, no bubbles
    @(posedge clk); #1;
    p0 = pops;
    send(2'b00, 3'b010, 1'b0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    send(2'b10, 3'b111, 1'b0, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0);
    send(2'b10, 3'b001, 1'b0, 32'd1, 32'd4, 32'd16, 1'b0, 1'b0);
    send(2'b10, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0);
    chk("b2b_pops_mid", 32'(pops - p0), 32'd2);
    idle();
    repeat (2) @(negedge clk);
    #1 chk("b2b_pops_end", 32'(pops - p0), 32'd4);
    @(negedge clk);
    chk("b2b_out_drop", 32'(out_valid), 32'd0);

    // Backpressure with both stages full
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(2'b10, 3'b100, 1'b0, 32'hFF, 32'h0F, 32'hF0, 1'b0, 1'b0);
    send(2'b10, 3'b110, 1'b0, 32'h100, 32'h1, 32'h101, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_result", result, 32'hF0);
      chk("stall_operation", 32'(Operation), 32'h1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    p0 = pops;
    repeat (2) @(negedge clk);
    #1 chk("stall_drain_pops", 32'(pops - p0), 32'd2);

    // Illegal requests
    @(posedge clk); #1;
    send(2'b11, 3'b000, 1'b0, 32'hFF, 32'hFF, 32'd0, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    chk("ill_operation", 32'(Operation), 32'h0);
    @(posedge clk); #1;
    send(2'b10, 3'b011, 1'b0, 32'hFF, 32'hFF, 32'd0, 1'b0, 1'b1);
    send(2'b01, 3'b010, 1'b0, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1);
    idle();
    repeat (3) @(negedge clk);

    // Reset with both stages full
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(2'b00, 3'b000, 1'b0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
    send(2'b00, 3'b000, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("prerst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_in_ready", 32'(in_ready), 32'd1);
    chk("rst2_result", result, 32'd0);
    chk("rst2_taken", 32'(branch_taken), 32'd0);
    chk("rst2_illegal", 32'(illegal), 32'd0);
    chk("rst2_srca", SrcA, 32'd0);
    chk("rst2_srcb", SrcB, 32'd0);
    chk("rst2_operation", 32'(Operation), 32'd0);

    // Recovery after reset
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'b10, 3'b100, 1'b0, 32'd6, 32'd3, 32'd5, 1'b0, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
